// File: rtl/quad_mux_arbiter.sv
// Round-robin arbiter and sequencer for two 4-bit burst requesters sharing one mux.
// Moves granted beats into a registered valid/ready output stage and owns the mux select.
module quad_mux_arbiter (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       req0,
    input  logic       req1,
    input  logic [1:0] len0,
    input  logic [1:0] len1,
    input  logic [3:0] data0,
    input  logic [3:0] data1,
    output logic       ack0,
    output logic       ack1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       src,
    output logic [3:0] dataout,
    output logic       valid,
    output logic       last,
    input  logic       ready
);
    typedef enum logic {IDLE, BURST} state_t;

    state_t     state_q, state_d;
    logic       gnt0_q, gnt0_d;
    logic       gnt1_q, gnt1_d;
    logic       src_q, src_d;
    logic       prio_q, prio_d;
    logic [2:0] cnt_q, cnt_d;
    logic [3:0] dataout_q, dataout_d;
    logic       valid_q, valid_d;
    logic       last_q, last_d;

    logic       req_g;
    logic [3:0] data_g;
    logic       ld;
    logic       win;
    logic [1:0] len_win;

    // While in BURST the granted requester is always the one selected by src_q
    assign req_g   = src_q ? req1 : req0;
    assign data_g  = src_q ? data1 : data0;
    assign ld      = (state_q == BURST) && req_g && (!valid_q || ready);
    assign win     = (req0 && req1) ? prio_q : req1;
    assign len_win = win ? len1 : len0;

    always_comb begin
        state_d   = state_q;
        gnt0_d    = gnt0_q;
        gnt1_d    = gnt1_q;
        src_d     = src_q;
        prio_d    = prio_q;
        cnt_d     = cnt_q;
        dataout_d = dataout_q;
        valid_d   = valid_q;
        last_d    = last_q;

        if (ld) begin
            dataout_d = data_g;
            valid_d   = 1'b1;
            last_d    = (cnt_q == 3'd1);
            cnt_d     = cnt_q - 3'd1;
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    state_d = BURST;
                    gnt0_d  = !win;
                    gnt1_d  = win;
                    src_d   = win;
                    cnt_d   = {1'b0, len_win} + 3'd1;
                end
            end
            BURST: begin
                // Final beat and abort both end the burst and hand priority over
                if (!req_g || (ld && cnt_q == 3'd1)) begin
                    state_d = IDLE;
                    gnt0_d  = 1'b0;
                    gnt1_d  = 1'b0;
                    prio_d  = !src_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            src_q     <= 1'b0;
            prio_q    <= 1'b0;
            cnt_q     <= '0;
            dataout_q <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt0_q    <= gnt0_d;
            gnt1_q    <= gnt1_d;
            src_q     <= src_d;
            prio_q    <= prio_d;
            cnt_q     <= cnt_d;
            dataout_q <= dataout_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
        end
    end

    assign ack0    = ld && !src_q;
    assign ack1    = ld && src_q;
    assign gnt0    = gnt0_q;
    assign gnt1    = gnt1_q;
    assign src     = src_q;
    assign dataout = dataout_q;
    assign valid   = valid_q;
    assign last    = last_q;
endmodule

// File: tb/tb_quad_mux_arbiter.sv
// Self-checking bench for quad_mux_arbiter: directed scenarios plus randomized
// requester/consumer traffic scored against a transaction-level model.
module tb_quad_mux_arbiter;
    logic       clk = 1'b0;
    logic       reset_n;
    logic       req0, req1;
    logic [1:0] len0, len1;
    logic [3:0] data0, data1;
    logic       ack0, ack1, gnt0, gnt1, src;
    logic [3:0] dataout;
    logic       valid, last, ready;

    int errors = 0;
    int checks = 0;

    quad_mux_arbiter dut (
        .clk     (clk),
        .reset_n (reset_n),
        .req0    (req0),
        .req1    (req1),
        .len0    (len0),
        .len1    (len1),
        .data0   (data0),
        .data1   (data1),
        .ack0    (ack0),
        .ack1    (ack1),
        .gnt0    (gnt0),
        .gnt1    (gnt1),
        .src     (src),
        .dataout (dataout),
        .valid   (valid),
        .last    (last),
        .ready   (ready)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected to finish earlier", $time);
        $fatal(1);
    end

    task automatic do_reset;
        reset_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0; len0 = 2'd0; len1 = 2'd0;
        data0 = 4'h0; data1 = 4'h0; ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset;
        logic [10:0] obs;
        reset_n = 1'b0;
        req0 = 1'b1; req1 = 1'b1; len0 = 2'd3; len1 = 2'd3;
        data0 = 4'hF; data1 = 4'hF; ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        obs = {gnt0, gnt1, src, dataout, valid, last, ack0, ack1};
        checks++;
        if (obs !== 11'b0) begin
            errors++;
            $display("FAIL reset_state: outputs=%b expected all zero", obs);
        end
        do_reset();
    endtask

    task automatic test_single;
        do_reset();
        @(posedge clk); #1;
        req0 = 1'b1; len0 = 2'd2; data0 = 4'h1;
        @(negedge clk);
        checks++;
        if ({gnt0, gnt1, ack0} !== 3'b000) begin
            errors++;
            $display("FAIL single_pre_grant: gnt0,gnt1,ack0=%b expected 000", {gnt0, gnt1, ack0});
        end
        for (int b = 1; b <= 3; b++) begin
            @(negedge clk);
            checks++;
            if ({gnt0, gnt1, src, ack0, ack1} !== 5'b10010) begin
                errors++;
                $display("FAIL single_ack%0d: gnt0,gnt1,src,ack0,ack1=%b expected 10010", b,
                         {gnt0, gnt1, src, ack0, ack1});
            end
            if (b > 1) begin
                checks++;
                if ({valid, last, dataout} !== {2'b10, 4'(b - 1)}) begin
                    errors++;
                    $display("FAIL single_beat%0d: valid,last,dataout=%b expected %b", b - 1,
                             {valid, last, dataout}, {2'b10, 4'(b - 1)});
                end
            end
            @(posedge clk); #1;
            if (b == 3) req0 = 1'b0;
            else data0 = 4'(b + 1);
        end
        @(negedge clk);
        checks++;
        if ({gnt0, gnt1, ack0, valid, last, dataout} !== {3'b000, 2'b11, 4'h3}) begin
            errors++;
            $display("FAIL single_last: gnt0,gnt1,ack0,valid,last,dataout=%b expected 000110011",
                     {gnt0, gnt1, ack0, valid, last, dataout});
        end
        // Both requesting now: priority must have moved to requester 1
        @(posedge clk); #1;
        req0 = 1'b1; req1 = 1'b1; len0 = 2'd0; len1 = 2'd0;
        @(negedge clk);
        checks++;
        if ({gnt0, gnt1, valid} !== 3'b000) begin
            errors++;
            $display("FAIL single_idle: gnt0,gnt1,valid=%b expected 000", {gnt0, gnt1, valid});
        end
        @(negedge clk);
        checks++;
        if ({gnt0, gnt1, src} !== 3'b011) begin
            errors++;
            $display("FAIL single_prio: gnt0,gnt1,src=%b expected 011", {gnt0, gnt1, src});
        end
        @(posedge clk); #1;
        req0 = 1'b0; req1 = 1'b0;
    endtask

    task automatic test_simultaneous;
        do_reset();
        @(posedge clk); #1;
        req0 = 1'b1; req1 = 1'b1; len0 = 2'd0; len1 = 2'd0; data0 = 4'hA; data1 = 4'h5;
        @(negedge clk);
        checks++;
        if ({gnt0, gnt1} !== 2'b00) begin
            errors++;
            $display("FAIL simul_c1: gnt0,gnt1=%b expected 00", {gnt0, gnt1});
        end
        @(negedge clk);
        checks++;
        if ({gnt0, gnt1, src, ack0, ack1} !== 5'b10010) begin
            errors++;
            $display("FAIL simul_grant0: gnt0,gnt1,src,ack0,ack1=%b expected 10010",
                     {gnt0, gnt1, src, ack0, ack1});
        end
        @(posedge clk); #1;
        req0 = 1'b0;
        @(negedge clk);
        checks++;
        if ({gnt0, gnt1, src, valid, last, dataout} !== {5'b00011, 4'hA}) begin
            errors++;
            $display("FAIL simul_gap: gnt0,gnt1,src,valid,last,dataout=%b expected 000111010",
                     {gnt0, gnt1, src, valid, last, dataout});
        end
        @(negedge clk);
        checks++;
        if ({gnt0, gnt1, src, ack0, ack1, valid} !== 6'b011010) begin
            errors++;
            $display("FAIL simul_grant1: gnt0,gnt1,src,ack0,ack1,valid=%b expected 011010",
                     {gnt0, gnt1, src, ack0, ack1, valid});
        end
        @(posedge clk); #1;
        req1 = 1'b0;
        @(negedge clk);
        checks++;
        if ({gnt1, valid, last, dataout} !== {3'b011, 4'h5}) begin
            errors++;
            $display("FAIL simul_beat1: gnt1,valid,last,dataout=%b expected 0110101",
                     {gnt1, valid, last, dataout});
        end
    endtask

    task automatic test_alternate;
        int         n;
        logic [1:0] prev, expg;
        do_reset();
        @(posedge clk); #1;
        req0 = 1'b1; req1 = 1'b1; len0 = 2'd0; len1 = 2'd0; data0 = 4'h3; data1 = 4'hC;
        n = 0;
        prev = 2'b00;
        for (int c = 0; c < 40 && n < 6; c++) begin
            @(negedge clk);
            checks++;
            if (gnt0 && gnt1) begin
                errors++;
                $display("FAIL alt_exclusive: gnt0,gnt1=11 expected at most one high");
            end
            if ({gnt1, gnt0} != 2'b00 && prev == 2'b00) begin
                expg = (n % 2 == 0) ? 2'b01 : 2'b10;
                checks++;
                if ({gnt1, gnt0} !== expg) begin
                    errors++;
                    $display("FAIL alt_grant%0d: gnt1,gnt0=%b expected %b", n, {gnt1, gnt0}, expg);
                end
                n++;
            end
            prev = {gnt1, gnt0};
        end
        checks++;
        if (n != 6) begin
            errors++;
            $display("FAIL alt_count: grants seen=%0d expected 6", n);
        end
        @(posedge clk); #1;
        req0 = 1'b0; req1 = 1'b0;
    endtask

    task automatic test_backpressure;
        int   sent, got;
        logic ack_prev;
        do_reset();
        @(posedge clk); #1;
        req1 = 1'b1; len1 = 2'd3; data1 = 4'h6;
        sent = 0; got = 0; ack_prev = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            if (ack_prev) begin
                sent++;
                if (sent == 4) req1 = 1'b0;
                else data1 = 4'(6 + sent);
            end
            ready = !(c >= 2 && c <= 4);
            @(negedge clk);
            if (c >= 2 && c <= 4) begin
                checks++;
                if ({ack1, valid, dataout} !== {2'b01, 4'h6}) begin
                    errors++;
                    $display("FAIL bp_stall_c%0d: ack1,valid,dataout=%b expected 010110", c,
                             {ack1, valid, dataout});
                end
            end
            if (valid && ready) begin
                checks++;
                if ({last, dataout} !== {(got == 3), 4'(6 + got)}) begin
                    errors++;
                    $display("FAIL bp_beat%0d: last,dataout=%b expected %b", got, {last, dataout},
                             {(got == 3), 4'(6 + got)});
                end
                got++;
            end
            ack_prev = ack1;
        end
        checks++;
        if (sent != 4 || got != 4 || valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_totals: acked=%0d delivered=%0d valid=%b expected 4 4 0", sent, got, valid);
        end
    endtask

    task automatic test_abort;
        do_reset();
        @(posedge clk); #1;
        req1 = 1'b1; len1 = 2'd3; data1 = 4'h1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if ({gnt1, src, ack1} !== 3'b111) begin
            errors++;
            $display("FAIL abort_grant: gnt1,src,ack1=%b expected 111", {gnt1, src, ack1});
        end
        @(posedge clk); #1;
        data1 = 4'h2; req0 = 1'b1; len0 = 2'd0; data0 = 4'hC;
        @(negedge clk);
        checks++;
        if ({ack0, ack1, valid, last, dataout} !== {4'b0110, 4'h1}) begin
            errors++;
            $display("FAIL abort_beat0: ack0,ack1,valid,last,dataout=%b expected 01100001",
                     {ack0, ack1, valid, last, dataout});
        end
        @(posedge clk); #1;
        req1 = 1'b0;
        @(negedge clk);
        checks++;
        if ({ack0, ack1, valid, last, dataout} !== {4'b0010, 4'h2}) begin
            errors++;
            $display("FAIL abort_cycle: ack0,ack1,valid,last,dataout=%b expected 00100010",
                     {ack0, ack1, valid, last, dataout});
        end
        @(negedge clk);
        checks++;
        if ({gnt0, gnt1, valid, last} !== 4'b0000) begin
            errors++;
            $display("FAIL abort_idle: gnt0,gnt1,valid,last=%b expected 0000", {gnt0, gnt1, valid, last});
        end
        @(negedge clk);
        checks++;
        if ({gnt0, gnt1, src, ack0} !== 4'b1001) begin
            errors++;
            $display("FAIL abort_next: gnt0,gnt1,src,ack0=%b expected 1001", {gnt0, gnt1, src, ack0});
        end
        @(posedge clk); #1;
        req0 = 1'b0;
        @(negedge clk);
        checks++;
        if ({valid, last, dataout} !== {2'b11, 4'hC}) begin
            errors++;
            $display("FAIL abort_req0_beat: valid,last,dataout=%b expected 111100", {valid, last, dataout});
        end
    endtask

    task automatic test_async_reset;
        logic [10:0] obs;
        do_reset();
        @(posedge clk); #1;
        req1 = 1'b1; len1 = 2'd3; data1 = 4'h5;
        @(posedge clk); #1;
        @(posedge clk); #1;
        data1 = 4'h6;
        #2;
        reset_n = 1'b0;
        #1;
        obs = {gnt0, gnt1, src, dataout, valid, last, ack0, ack1};
        checks++;
        if (obs !== 11'b0) begin
            errors++;
            $display("FAIL areset_immediate: outputs=%b expected all zero", obs);
        end
        len1 = 2'd1; data1 = 4'h9;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({gnt0, gnt1, src, ack1, valid} !== 5'b01110) begin
            errors++;
            $display("FAIL areset_regrant: gnt0,gnt1,src,ack1,valid=%b expected 01110",
                     {gnt0, gnt1, src, ack1, valid});
        end
        @(posedge clk); #1;
        req1 = 1'b0;
    endtask

    task automatic test_random;
        logic [3:0] q_data[$];
        bit         q_last[$];
        bit         rq[2];
        logic [1:0] ln[2];
        logic [3:0] dt[2];
        int         idx[2];
        logic [1:0] a, pg, pr, pa, expg, expa;
        logic       psrc, expsrc, mprio, pfinal, pend, stop, mvalid;
        logic [3:0] ed;
        bit         el;
        int         delivered;
        do_reset();
        for (int r = 0; r < 2; r++) begin
            rq[r] = 1'b0; ln[r] = 2'd0; dt[r] = 4'h0; idx[r] = 0;
        end
        a = 2'b00; pg = 2'b00; pr = 2'b00; pa = 2'b00;
        psrc = 1'b0; mprio = 1'b0; pfinal = 1'b0; delivered = 0;
        for (int c = 0; c < 700; c++) begin
            stop = (c >= 640);
            @(posedge clk); #1;
            // Requester agents: advance on ack, start/finish bursts, occasionally abort
            for (int r = 0; r < 2; r++) begin
                if (a[r]) begin
                    if (idx[r] == int'(ln[r])) begin
                        if (!stop && $urandom_range(0, 9) < 5) begin
                            ln[r] = 2'($urandom_range(0, 3)); dt[r] = 4'($urandom); idx[r] = 0;
                        end else begin
                            rq[r] = 1'b0;
                        end
                    end else begin
                        idx[r]++;
                        dt[r] = 4'($urandom);
                    end
                end else if (!rq[r]) begin
                    if (!stop && $urandom_range(0, 9) < 3) begin
                        rq[r] = 1'b1; ln[r] = 2'($urandom_range(0, 3)); dt[r] = 4'($urandom); idx[r] = 0;
                    end
                end else if (pg[r] && $urandom_range(0, 29) == 0) begin
                    rq[r] = 1'b0;
                end
            end
            ready = stop ? 1'b1 : ($urandom_range(0, 3) != 0);
            req0 = rq[0]; req1 = rq[1]; len0 = ln[0]; len1 = ln[1]; data0 = dt[0]; data1 = dt[1];
            @(negedge clk);
            a = {ack1, ack0};
            if (pg == 2'b00) begin
                expg = (pr == 2'b11) ? (mprio ? 2'b10 : 2'b01) : pr;
            end else begin
                pend = (pa != 2'b00 && pfinal) || ((pr & pg) == 2'b00);
                expg = pend ? 2'b00 : pg;
                if (pend) mprio = pg[0];
            end
            expsrc = (expg != 2'b00) ? expg[1] : psrc;
            mvalid = (q_data.size() != 0);
            expa = (mvalid && !ready) ? 2'b00 : (expg & {rq[1], rq[0]});
            checks++;
            if ({gnt1, gnt0} !== expg) begin
                errors++;
                $display("FAIL rand_gnt c%0d: gnt1,gnt0=%b expected %b", c, {gnt1, gnt0}, expg);
            end
            checks++;
            if (src !== expsrc) begin
                errors++;
                $display("FAIL rand_src c%0d: src=%b expected %b", c, src, expsrc);
            end
            checks++;
            if (a !== expa) begin
                errors++;
                $display("FAIL rand_ack c%0d: ack1,ack0=%b expected %b", c, a, expa);
            end
            checks++;
            if (valid !== mvalid) begin
                errors++;
                $display("FAIL rand_valid c%0d: valid=%b expected %b", c, valid, mvalid);
            end
            if (mvalid && ready) begin
                ed = q_data.pop_front();
                el = q_last.pop_front();
                checks++;
                if ({last, dataout} !== {el, ed}) begin
                    errors++;
                    $display("FAIL rand_beat c%0d: last,dataout=%b expected %b", c, {last, dataout}, {el, ed});
                end
                delivered++;
            end
            pfinal = 1'b0;
            for (int r = 0; r < 2; r++) begin
                if (a[r]) begin
                    q_data.push_back(dt[r]);
                    q_last.push_back(idx[r] == int'(ln[r]));
                    pfinal = (idx[r] == int'(ln[r]));
                end
            end
            pg = expg; pr = {rq[1], rq[0]}; pa = a; psrc = expsrc;
        end
        checks++;
        if (q_data.size() != 0 || valid !== 1'b0) begin
            errors++;
            $display("FAIL rand_drain: pending=%0d valid=%b expected 0 0", q_data.size(), valid);
        end
        checks++;
        if (delivered < 100) begin
            errors++;
            $display("FAIL rand_volume: delivered=%0d expected at least 100", delivered);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_alternate();
        test_backpressure();
        test_abort();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
